reaction_timer_multi: RTL and testbench

//  Parametrised N-player reaction timer: successor of the single-player lab timer.
//  A start pulse begins a programmable delay in whole seconds. After it, led_go lights
//  and a shared DIGITS-digit BCD millisecond counter runs; each player's first press latches

---
 rtl/rt_pkg.sv | 21 ++
 rtl/bcd_counter_sat.sv | 51 +++++
 rtl/reaction_timer_multi.sv | 172 +++++++++++++++++
 tb/tb_reaction_timer_multi.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rt_pkg.sv
// Shared types and sizing helpers for the multi-player reaction timer.
package rt_pkg;

  localparam int DEF_CLK_HZ  = 50_000_000;
  localparam int DEF_TICK_HZ = 1000;
  localparam int DIV         = DEF_CLK_HZ / DEF_TICK_HZ;
  localparam int BCD_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } rtState;

  // Bits needed for a counter that runs 0..n-1 (never less than one bit).
  function automatic int cntWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bcd_counter_sat.sv
// Cascaded BCD up-counter that clears on demand and holds at all-nines.
module bcd_counter_sat
  import rt_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  input  logic                    clr,
  input  logic                    inc,
  output logic [BCD_W*DIGITS-1:0] value,
  output logic                    at_max
);

  localparam logic [BCD_W*DIGITS-1:0] MAX_VALUE = {DIGITS{4'h9}};

  logic [BCD_W*DIGITS-1:0] nextValue;

  assign at_max = (value == MAX_VALUE);

  // Ripple a +1 from the least significant digit, wrapping 9 -> 0 with carry.
  always_comb begin : incCalc
    logic carry;
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    nextValue = value;
    carry     = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (value[d*BCD_W +: BCD_W] == 4'd9) begin
          nextValue[d*BCD_W +: BCD_W] = 4'd0;
        end else begin
          nextValue[d*BCD_W +: BCD_W] = value[d*BCD_W +: BCD_W] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  // Counter register: clear wins, increments stop once all digits read 9.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!RESET_N) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && !at_max) begin
      value <= nextValue;
    end
  end

endmodule

// File: rtl/reaction_timer_multi.sv
// N-player reaction timer: programmable seconds delay, shared BCD ms counter,
// per-player capture with false-start exclusion and overflow on saturation.
module reaction_timer_multi
  import rt_pkg::*;
#(
  parameter int CLK_HZ  = DIV * DEF_TICK_HZ,
  parameter int TICK_HZ = DEF_TICK_HZ,
  parameter int DIGITS  = 4,
  parameter int PLAYERS = 2,
  parameter int DELAY_W = 8
) (
  input  logic                          CLOCK_50,
  input  logic                          RESET_N,
  input  logic                          start,
  input  logic [DELAY_W-1:0]            delay_s,
  input  logic [PLAYERS-1:0]            react_n,
  output logic                          led_go,
  output logic                          busy,
  output logic [PLAYERS*DIGITS*4-1:0]   bcd_time,
  output logic [PLAYERS-1:0]            valid,
  output logic [PLAYERS-1:0]            false_start,
  output logic                          overflow
);

  localparam int DIV_CYCLES = CLK_HZ / TICK_HZ;
  localparam int PRE_W      = cntWidth(DIV_CYCLES);
  localparam int SUB_W      = cntWidth(TICK_HZ);
  localparam int VAL_W      = BCD_W * DIGITS;

  rtState               state;
  logic [PLAYERS-1:0]   sync1, sync2, syncPrev, press;
  logic [PRE_W-1:0]     preCnt;
  logic                 tick;
  logic [SUB_W-1:0]     subCnt;
  logic [DELAY_W-1:0]   secCnt, delayLat;
  logic                 secTick, delayHit;
  logic [PLAYERS-1:0]   fsNext, capEn, validNext;
  logic                 goWait, goRun, allFalse, allReacted, satPending;
  logic [VAL_W-1:0]     count;
  logic                 atMax;

  // Falling edge of the synchronised button is a one-cycle press.
  assign press = syncPrev & ~sync2;

  assign tick    = (preCnt == PRE_W'(DIV_CYCLES - 1));
  assign secTick = tick && (subCnt == SUB_W'(TICK_HZ - 1));

  // Leave WAIT on the same edge that sec_cnt reaches the latched delay, so led_go
  // rises exactly delay*CLK_HZ cycles after WAIT entry; a zero delay leaves at once.
  assign delayHit = (delayLat == '0) || (secTick && (secCnt == delayLat - DELAY_W'(1)));

  assign fsNext    = false_start | (press & {PLAYERS{state == WAIT}});
  assign capEn     = press & ~valid & ~false_start & {PLAYERS{state == RUN}};
  assign validNext = valid | capEn;

  assign goWait     = start && ((state == IDLE) || (state == DONE));
  assign allFalse   = (state == WAIT) && (&fsNext);
  assign goRun      = (state == WAIT) && delayHit && !allFalse;
  assign allReacted = &(valid | false_start);
  assign satPending = atMax && !(&(validNext | false_start));

  bcd_counter_sat #(
    .DIGITS (DIGITS)
  ) u_counter (
    .CLOCK_50 (CLOCK_50),
    .RESET_N  (RESET_N),
    .clr      (goWait || goRun),
    .inc      ((state == RUN) && tick),
    .value    (count),
    .at_max   (atMax)
  );

  // Two-flop synchroniser plus edge-detect history for the raw buttons.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      // NOTE: synchroniser flops reset to the released (high) level so leaving reset never fakes a press.
      sync1    <= '1;
      sync2    <= '1;
      syncPrev <= '1;
    end else begin
      sync1    <= react_n;
      sync2    <= sync1;
      syncPrev <= sync2;
    end
  end

  // Prescaler: restarts on WAIT and RUN entry so the first tick lands a full period later.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      preCnt <= '0;
    end else if (goWait || goRun || tick) begin
      preCnt <= '0;
    end else begin
      preCnt <= preCnt + PRE_W'(1);
    end
  end

  // Whole-second timebase used only while waiting for the go signal.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      subCnt <= '0;
      secCnt <= '0;
    end else if (goWait) begin
      subCnt <= '0;
      secCnt <= '0;
    end else if ((state == WAIT) && tick) begin
      if (secTick) begin
        subCnt <= '0;
        secCnt <= secCnt + DELAY_W'(1);
      end else begin
        subCnt <= subCnt + SUB_W'(1);
      end
    end
  end

  // Round FSM with registered decodes and per-player capture registers.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= IDLE;
      led_go      <= 1'b0;
      busy        <= 1'b0;
      delayLat    <= '0;
      valid       <= '0;
      false_start <= '0;
      overflow    <= 1'b0;
      bcd_time    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (goWait) begin
            state       <= WAIT;
            busy        <= 1'b1;
            led_go      <= 1'b0;
            delayLat    <= delay_s;
            valid       <= '0;
            false_start <= '0;
            overflow    <= 1'b0;
            bcd_time    <= '0;
          end
        end
        WAIT: begin
          false_start <= fsNext;
          if (allFalse) begin
            state <= DONE;
            busy  <= 1'b0;
          end else if (goRun) begin
            state  <= RUN;
            led_go <= 1'b1;
          end
        end
        RUN: begin
          valid <= validNext;
          for (int p = 0; p < PLAYERS; p++) begin
            if (capEn[p]) bcd_time[p*VAL_W +: VAL_W] <= count;
          end
          if (allReacted) begin
            state  <= DONE;
            led_go <= 1'b0;
            busy   <= 1'b0;
          end else if (satPending) begin
            state    <= DONE;
            led_go   <= 1'b0;
            busy     <= 1'b0;
            overflow <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_timer_multi.sv
// Self-checking bench: scoreboard of expected captures plus direct round checks.
module tb_reaction_timer_multi;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIGITS  = 4;
  localparam int PLAYERS = 2;
  localparam int DELAY_W = 8;
  localparam int D       = CLK_HZ / TICK_HZ;
  localparam int VW      = 4 * DIGITS;

  typedef struct {
    int          player;
    logic [15:0] value;
  } capT;

  logic        CLOCK_50 = 1'b0;
  logic        RESET_N  = 1'b0;
  logic        start    = 1'b0;
  logic [7:0]  delay_s  = '0;
  logic [1:0]  react_n  = '1;
  logic        led_go, busy, overflow;
  logic [31:0] bcd_time;
  logic [1:0]  valid, false_start;

  logic        satStart = 1'b0;
  logic [7:0]  satDelay = '0;
  logic [1:0]  satReact = '1;
  logic        satLed, satBusy, satOvf;
  logic [31:0] satBcd;
  logic [1:0]  satValid, satFs;

  int  vectors = 0;
  int  miscompares = 0;
  int  cycleNo = 0;
  int  entryEdge = 0;
  capT expQ[$];
  capT mon;
  logic [1:0] prevValid = '0;

  reaction_timer_multi #(
    .CLK_HZ (CLK_HZ), .TICK_HZ (TICK_HZ), .DIGITS (DIGITS),
    .PLAYERS (PLAYERS), .DELAY_W (DELAY_W)
  ) dut (
    .CLOCK_50 (CLOCK_50), .RESET_N (RESET_N), .start (start), .delay_s (delay_s),
    .react_n (react_n), .led_go (led_go), .busy (busy), .bcd_time (bcd_time),
    .valid (valid), .false_start (false_start), .overflow (overflow)
  );

  // Second instance with a 2-cycle tick so a full 4-digit saturation stays short.
  reaction_timer_multi #(
    .CLK_HZ (200), .TICK_HZ (100), .DIGITS (DIGITS),
    .PLAYERS (PLAYERS), .DELAY_W (DELAY_W)
  ) satDut (
    .CLOCK_50 (CLOCK_50), .RESET_N (RESET_N), .start (satStart), .delay_s (satDelay),
    .react_n (satReact), .led_go (satLed), .busy (satBusy), .bcd_time (satBcd),
    .valid (satValid), .false_start (satFs), .overflow (satOvf)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cycleNo <= cycleNo + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] toBcd(input int n);
    logic [15:0] r;
    int v;
    v = n;
    for (int d = 0; d < 4; d++) begin
      r[d*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic waitNeg(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic startRound(input logic [7:0] d);
    @(negedge CLOCK_50);
    delay_s = d;
    start   = 1'b1;
    @(negedge CLOCK_50);
    start     = 1'b0;
    entryEdge = cycleNo;
  endtask

  task automatic waitLedGo(input int budget, output int runEdge);
    int n;
    n = 0;
    while (!led_go && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("led_go_seen", {31'b0, led_go}, 32'd1);
    runEdge = cycleNo;
  endtask

  // Drive the pins so the capture lands on edge capEdge and queue the expected value.
  task automatic pressAt(input logic [1:0] mask, input int capEdge, input int runEdge);
    int ticks;
    capT c;
    while (cycleNo < capEdge - 3) @(negedge CLOCK_50);
    ticks = (capEdge - runEdge - 1) / D;
    for (int p = 0; p < PLAYERS; p++) begin
      if (mask[p]) begin
        c.player = p;
        c.value  = toBcd(ticks);
        expQ.push_back(c);
      end
    end
    react_n = react_n & ~mask;
    waitNeg(3);
    react_n = react_n | mask;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    check(tag, {31'b0, busy}, 32'd0);
  endtask

  // Scoreboard monitor: each rising valid bit must match the oldest expected capture.
  always @(negedge CLOCK_50) begin
    for (int p = 0; p < PLAYERS; p++) begin
      if (valid[p] && !prevValid[p]) begin
        if (expQ.size() == 0) begin
          check("sb_unexpected_capture", expQ.size(), 32'd1);
        end else begin
          mon = expQ.pop_front();
          check("sb_player", p, mon.player);
          check("sb_bcd", {16'b0, bcd_time[p*VW +: VW]}, {16'b0, mon.value});
        end
      end
    end
    prevValid = valid;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  initial begin
    int r;
    int satEntry;
    int n;

    // Reset state
    waitNeg(3);
    check("rst_flags", {25'b0, led_go, busy, overflow, valid, false_start}, 32'd0);
    check("rst_bcd", bcd_time, 32'd0);
    RESET_N = 1'b1;
    waitNeg(2);

    // 1: two-second delay, staggered presses
    startRound(8'd2);
    waitLedGo(2500, r);
    check("t1_go_delay", r - entryEdge, 32'd2000);
    pressAt(2'b01, r + 37*D + 5, r);
    pressAt(2'b10, r + 52*D + 5, r);
    waitDone("t1_done", 20);
    check("t1_valid", {30'b0, valid}, 32'd3);
    check("t1_flags", {29'b0, led_go, overflow, |false_start}, 32'd0);

    // 2: false start by P1, P0 alone decides the round
    startRound(8'd1);
    waitNeg(300);
    react_n[1] = 1'b0;
    waitNeg(4);
    react_n[1] = 1'b1;
    check("t2_fs_in_wait", {30'b0, false_start}, 32'd2);
    check("t2_wait_state", {30'b0, busy, led_go}, 32'd2);
    waitLedGo(1500, r);
    check("t2_go_delay", r - entryEdge, 32'd1000);
    pressAt(2'b01, r + 9*D + 5, r);
    check("t2_run_after_cap", {31'b0, busy}, 32'd1);
    @(negedge CLOCK_50);
    check("t2_done_next", {31'b0, busy}, 32'd0);
    check("t2_valid", {30'b0, valid}, 32'd1);
    check("t2_fs", {30'b0, false_start}, 32'd2);
    check("t2_p1_bcd", {16'b0, bcd_time[31:16]}, 32'd0);

    // 3: saturation with nobody pressing
    @(negedge CLOCK_50);
    satDelay = 8'd0;
    satStart = 1'b1;
    @(negedge CLOCK_50);
    satStart = 1'b0;
    satEntry = cycleNo;
    n = 0;
    while (satBusy && n < 25000) begin
      @(negedge CLOCK_50);
      n++;
    end
    check("t3_done", {31'b0, satBusy}, 32'd0);
    check("t3_done_edge", cycleNo - satEntry, 32'd20000);
    check("t3_overflow", {31'b0, satOvf}, 32'd1);
    check("t3_valid_bcd", {satValid, satFs, satLed, 27'b0} | {5'b0, 11'b0, satBcd[15:0] | satBcd[31:16]}, 32'd0);
    check("t3_count_held", {16'b0, satDut.count}, 32'h9999);

    // 4: simultaneous presses on a tick edge at 0x0199
    startRound(8'd0);
    check("t4_fs_cleared", {30'b0, false_start}, 32'd0);
    waitLedGo(5, r);
    check("t4_go_delay", r - entryEdge, 32'd1);
    pressAt(2'b11, r + 200*D, r);
    check("t4_count_after", {16'b0, dut.count}, 32'h0200);
    waitDone("t4_done", 20);
    check("t4_valid", {30'b0, valid}, 32'd3);

    // 5: reset mid-RUN, then a clean round
    startRound(8'd0);
    waitLedGo(5, r);
    pressAt(2'b01, r + 20*D + 5, r);
    waitNeg(50);
    RESET_N = 1'b0;
    #1;
    check("t5_rst_flags", {25'b0, led_go, busy, overflow, valid, false_start}, 32'd0);
    check("t5_rst_bcd", bcd_time, 32'd0);
    waitNeg(3);
    RESET_N = 1'b1;
    waitNeg(2);
    startRound(8'd0);
    waitLedGo(5, r);
    check("t5_go_delay", r - entryEdge, 32'd1);
    pressAt(2'b01, r + 5*D + 5, r);
    pressAt(2'b10, r + 12*D + 5, r);
    waitDone("t5_done", 20);
    check("t5_valid", {30'b0, valid}, 32'd3);

    // 6: re-arm from DONE clears results; starts during WAIT are ignored
    startRound(8'd3);
    check("t6_cleared", {valid, false_start, 27'b0, busy} | bcd_time[31:0], 32'd1);
    waitNeg(500);
    delay_s = 8'd0;
    start   = 1'b1;
    @(negedge CLOCK_50);
    start   = 1'b0;
    waitNeg(1000);
    start   = 1'b1;
    @(negedge CLOCK_50);
    start   = 1'b0;
    waitLedGo(4000, r);
    check("t6_go_delay", r - entryEdge, 32'd3000);
    pressAt(2'b11, r + 3*D + 5, r);
    waitDone("t6_done", 20);
    check("t6_valid", {30'b0, valid}, 32'd3);

    waitNeg(2);
    check("sb_drained", expQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
